data_mem_responder: RTL

- Responder end of the CPU MEM-stage data memory interface (mem_ren/mem_wen/mem_addr/mem_dout/mem_din).
- Services word loads and stores from the pipeline against an internal word-addressed RAM.
- Inserts a configurable number of wait states, signalling them through mem_stall so the hazard/stall controller freezes the pipeline.
- Flags misaligned, out-of-range and conflicting requests via mem_err.

---
 rtl/data_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: word RAM with WAIT_CYCLES wait states, stall and error signalling.
// Optional DMEM_DEBUG_EN adds debug_addr/debug_data with access counters and a RAM peek port.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
`ifdef DMEM_DEBUG_EN
  ,
  input  logic [5:0]  debug_addr,
  output logic [31:0] debug_data
`endif
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t                  state, next_state;
  logic [3:0]              cnt;
  logic                    lat_rd, lat_wr, lat_err;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic [31:0]             lat_wdata;
  logic [31:0]             ram [DEPTH];

  logic                    req, live_err, accept, resp;
  logic [ADDR_WIDTH-1:0]   live_idx;
  logic                    cur_rd, cur_wr, cur_err;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic [31:0]             cur_wdata;

  assign req      = mem_ren | mem_wen;
  assign live_idx = mem_addr[ADDR_WIDTH+1:2];
  assign live_err = (|mem_addr[1:0]) | (|mem_addr[31:ADDR_WIDTH+2]) | (mem_ren & mem_wen);
  assign accept   = rst_n && (state == S_IDLE) && req;
  assign resp     = rst_n && ((state == S_RESP) || (ZERO_WAIT && accept));

  // With zero wait states the acceptance cycle is the response, so the live request is used directly.
  assign cur_rd    = ZERO_WAIT ? mem_ren  : lat_rd;
  assign cur_wr    = ZERO_WAIT ? mem_wen  : lat_wr;
  assign cur_err   = ZERO_WAIT ? live_err : lat_err;
  assign cur_idx   = ZERO_WAIT ? live_idx : lat_idx;
  assign cur_wdata = ZERO_WAIT ? mem_dout : lat_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        cnt       <= 4'd1;
        lat_rd    <= mem_ren;
        lat_wr    <= mem_wen;
        lat_err   <= live_err;
        lat_idx   <= live_idx;
        lat_wdata <= mem_dout;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept && !ZERO_WAIT) next_state = (WAIT_CYCLES == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == LAST_WAIT) next_state = S_RESP;
      S_RESP: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    mem_din   = '0;
    if (rst_n && ((accept && !ZERO_WAIT) || state == S_WAIT)) mem_stall = 1'b1;
    if (resp) begin
      mem_err = cur_err;
      if (cur_rd && !cur_err) mem_din = ram[cur_idx];
    end
  end

  // RAM is deliberately not reset; writes land at the edge closing the response cycle.
  always_ff @(posedge clk) begin
    if (resp && cur_wr && !cur_err) ram[cur_idx] <= cur_wdata;
  end

`ifdef DMEM_DEBUG_EN
  logic [31:0] rd_cnt, wr_cnt, err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      err_cnt    <= '0;
      debug_data <= '0;
    end else begin
      if (resp) begin
        if (cur_err) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 32'd1;
        end else if (cur_rd) begin
          if (rd_cnt != '1) rd_cnt <= rd_cnt + 32'd1;
        end else if (cur_wr) begin
          if (wr_cnt != '1) wr_cnt <= wr_cnt + 32'd1;
        end
      end
      case (debug_addr)
        6'd0:    debug_data <= rd_cnt;
        6'd1:    debug_data <= wr_cnt;
        6'd2:    debug_data <= err_cnt;
        6'd3:    debug_data <= {28'b0, state, 2'b0};
        default: debug_data <= ram[ADDR_WIDTH'(debug_addr)];
      endcase
    end
  end
`endif

endmodule
